mux_scan_serializer: RTL and testbench
======================================

MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = scan select 0->7; 0 = scan select 7->0.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load_valid  input  1  upstream word offer.
REQ-005 load_ready  output  1  block accepts a word this cycle.
REQ-006 load_data  input  8  word to serialize.
REQ-007 mux_in  output  8  registered word driven to the 8:1 mux data input.
REQ-008 mux_sel  output  3  registered select driven to the 8:1 mux.
REQ-009 mux_out  input  1  combinational result returned from the 8:1 mux.
REQ-010 ser_valid  output  1  serial bit available.
REQ-011 ser_ready  input  1  downstream accepts the serial bit.
REQ-012 ser_data  output  1  serial bit, equal to mux_out AND ser_valid.
REQ-013 ser_last  output  1  the current bit is the final bit of the word.
REQ-014 busy  output  1  a word is being serialized.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-016 In IDLE: load_ready=1, ser_valid=0, busy=0, ser_data=0, ser_last=0.
REQ-017 In IDLE with load_valid=1: capture load_data into mux_in; set mux_sel to FIRST (0 if LSB_FIRST=1, else 7); go to SHIFT next cycle.
REQ-018 In SHIFT: load_ready=0, ser_valid=1, busy=1; load_valid and load_data SHALL be ignored.
REQ-019 ser_data SHALL pass mux_out through combinationally, with zero added latency from mux_sel/mux_in.
REQ-020 ser_last SHALL be 1 in SHIFT exactly when mux_sel equals LAST (7 if LSB_FIRST=1, else 0).
REQ-021 Transfer: a bit is consumed only on a cycle with ser_valid=1 and ser_ready=1.
REQ-022 On a transfer with ser_last=0: mux_sel steps by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0); no wrap-around occurs within a word.
REQ-023 On a transfer with ser_last=1: return to IDLE; mux_in holds its value; mux_sel returns to FIRST.
REQ-024 Stall (ser_ready=0 in SHIFT): mux_sel, mux_in, ser_data and ser_last SHALL hold stable; ser_valid SHALL stay 1.
REQ-025 Exactly 8 transfers per accepted word, in scan order, with no bit skipped or repeated.
REQ-026 At least one IDLE cycle separates words; with ser_ready held at 1, minimum throughput is 9 cycles per word.
REQ-027 mux_in SHALL change only on an IDLE accept.

Reset
REQ-028 With rst=1 at a clock edge: state=IDLE, mux_in=8'h00, mux_sel=FIRST.
REQ-029 Resulting outputs: load_ready=1, ser_valid=0, ser_data=0, ser_last=0, busy=0.
REQ-030 rst SHALL take priority over load_valid and ser_ready in every state.
REQ-031 Reset mid-SHIFT SHALL abandon the word; no further bits are emitted.

Verification
REQ-032 LSB_FIRST=1, load 8'b10110100, ser_ready=1 -> ser_data 0,0,1,0,1,1,0,1 on mux_sel 0..7; ser_last only with sel=7; load_ready=1 on the next cycle.
REQ-033 LSB_FIRST=0, same word -> bits 1,0,1,1,0,1,0,0 on mux_sel 7..0; ser_last only with sel=0.
REQ-034 Stall: drop ser_ready for 3 cycles after bit 2 -> mux_sel=2 and ser_data held for all 3 cycles; the full word still completes in the correct order.
REQ-035 Assert load_valid with 8'hFF during SHIFT of 8'h0F -> ignored; the stream stays 8'h0F and load_ready=0 throughout.
REQ-036 Assert rst for 1 cycle after bit 4 -> next cycle shows IDLE, mux_in=8'h00, ser_valid=0; a fresh load of 8'hA5 then serializes correctly.
REQ-037 Back-to-back: hold load_valid=1 with 8'h01 then 8'h80 -> second accept occurs exactly 9 cycles after the first.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Serializes one byte at a time by scanning the select of an external 8:1 mux.
// It presents the mux result as a valid/ready serial stream, one bit per transfer.
module mux_scan_serializer #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_data,
   output logic [7:0] mux_in,
   output logic [2:0] mux_sel,
   input  logic       mux_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_data,
   output logic       ser_last,
   output logic       busy
);

   localparam logic [2:0] FIRST = LSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [2:0] LAST  = LSB_FIRST ? 3'd7 : 3'd0;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state;

   // NOTE: every register in this block uses <=, so all of them see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mux_in     <= 8'h00;
         mux_sel    <= FIRST;
         load_ready <= 1'b1;
         ser_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  mux_in     <= load_data;
                  mux_sel    <= FIRST;
                  state      <= SHIFT;
                  load_ready <= 1'b0;
                  ser_valid  <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               // Without ser_ready nothing moves, so the presented bit holds.
               if (ser_ready) begin
                  if (mux_sel == LAST) begin
                     state      <= IDLE;
                     mux_sel    <= FIRST;
                     load_ready <= 1'b1;
                     ser_valid  <= 1'b0;
                     busy       <= 1'b0;
                  end else if (LSB_FIRST) begin
                     mux_sel <= mux_sel + 3'd1;
                  end else begin
                     mux_sel <= mux_sel - 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The mux result goes straight out, so no latency is added to the round trip.
   assign ser_data = mux_out & ser_valid;
   assign ser_last = ser_valid && (mux_sel == LAST);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Drives an LSB-first and an MSB-first serializer with the same stimulus and
// checks both against a scan-order model of the expected bit stream.
module tb_mux_scan_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       ser_ready;

   logic       load_ready_a, ser_valid_a, ser_data_a, ser_last_a, busy_a, mux_out_a;
   logic [7:0] mux_in_a;
   logic [2:0] mux_sel_a;
   logic       load_ready_b, ser_valid_b, ser_data_b, ser_last_b, busy_b, mux_out_b;
   logic [7:0] mux_in_b;
   logic [2:0] mux_sel_b;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   // External 8:1 muxes closing the loop.
   assign mux_out_a = mux_in_a[mux_sel_a];
   assign mux_out_b = mux_in_b[mux_sel_b];

   mux_scan_serializer #(.LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_a),
      .load_data(load_data), .mux_in(mux_in_a), .mux_sel(mux_sel_a), .mux_out(mux_out_a),
      .ser_valid(ser_valid_a), .ser_ready(ser_ready), .ser_data(ser_data_a),
      .ser_last(ser_last_a), .busy(busy_a)
   );

   mux_scan_serializer #(.LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_b),
      .load_data(load_data), .mux_in(mux_in_b), .mux_sel(mux_sel_b), .mux_out(mux_out_b),
      .ser_valid(ser_valid_b), .ser_ready(ser_ready), .ser_data(ser_data_b),
      .ser_last(ser_last_b), .busy(busy_b)
   );

   // k-th bit of a word goes out on select k (LSB first) or 7-k (MSB first).
   function automatic logic [2:0] exp_sel(input bit lsb, input int k);
      return lsb ? 3'(k) : 3'(7 - k);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input logic [7:0] exp_word);
      check("a_load_ready_idle", 8'(load_ready_a), 8'd1);
      check("b_load_ready_idle", 8'(load_ready_b), 8'd1);
      check("a_valid_idle", 8'(ser_valid_a), 8'd0);
      check("b_valid_idle", 8'(ser_valid_b), 8'd0);
      check("a_busy_idle", 8'(busy_a), 8'd0);
      check("b_busy_idle", 8'(busy_b), 8'd0);
      check("a_data_idle", 8'(ser_data_a), 8'd0);
      check("b_data_idle", 8'(ser_data_b), 8'd0);
      check("a_last_idle", 8'(ser_last_a), 8'd0);
      check("b_last_idle", 8'(ser_last_b), 8'd0);
      check("a_sel_idle", 8'(mux_sel_a), 8'd0);
      check("b_sel_idle", 8'(mux_sel_b), 8'd7);
      check("a_mux_in_idle", mux_in_a, exp_word);
      check("b_mux_in_idle", mux_in_b, exp_word);
   endtask

   task automatic check_shift(input int k, input logic [7:0] w);
      check("a_sel", 8'(mux_sel_a), 8'(exp_sel(1'b1, k)));
      check("b_sel", 8'(mux_sel_b), 8'(exp_sel(1'b0, k)));
      check("a_data", 8'(ser_data_a), 8'(w[exp_sel(1'b1, k)]));
      check("b_data", 8'(ser_data_b), 8'(w[exp_sel(1'b0, k)]));
      check("a_last", 8'(ser_last_a), 8'(k == 7));
      check("b_last", 8'(ser_last_b), 8'(k == 7));
      check("a_valid", 8'(ser_valid_a), 8'd1);
      check("b_valid", 8'(ser_valid_b), 8'd1);
      check("a_load_ready_shift", 8'(load_ready_a), 8'd0);
      check("b_load_ready_shift", 8'(load_ready_b), 8'd0);
      check("a_busy", 8'(busy_a), 8'd1);
      check("b_busy", 8'(busy_b), 8'd1);
      check("a_mux_in", mux_in_a, w);
      check("b_mux_in", mux_in_b, w);
   endtask

   task automatic accept(input logic [7:0] w);
      load_valid = 1'b1;
      load_data  = w;
      tick();
      load_valid = 1'b0;
      load_data  = 8'($urandom);
   endtask

   // Transfers n_bits of word w; stall_k/stall_len force a stall before bit stall_k,
   // rand_stall adds 0..2 random stall cycles before every bit.
   task automatic drain_word(input logic [7:0] w, input int n_bits, input int stall_k,
                             input int stall_len, input bit rand_stall);
      for (int k = 0; k < n_bits; k++) begin
         int stalls;
         check_shift(k, w);
         stalls = (k == stall_k) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s < stalls; s++) begin
            ser_ready = 1'b0;
            tick();
            check_shift(k, w);
         end
         ser_ready = 1'b1;
         tick();
      end
      if (n_bits == 8) check_idle(w);
   endtask

   initial begin
      int cycles;
      logic [7:0] w;

      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h5A;
      ser_ready  = 1'b1;
      tick();
      tick();
      // Reset wins over a pending load.
      check_idle(8'h00);
      rst        = 1'b0;
      load_valid = 1'b0;
      tick();
      check_idle(8'h00);

      // Directed word in both scan orders, then a 3-cycle stall after bit 2.
      accept(8'b1011_0100);
      drain_word(8'b1011_0100, 8, -1, 0, 1'b0);
      tick();
      accept(8'hC3);
      drain_word(8'hC3, 8, 2, 3, 1'b0);

      // A second offer during SHIFT is ignored.
      accept(8'h0F);
      load_valid = 1'b1;
      load_data  = 8'hFF;
      drain_word(8'h0F, 8, -1, 0, 1'b0);
      load_valid = 1'b0;
      tick();
      check_idle(8'h0F);

      // Reset after four bits abandons the word.
      accept(8'h96);
      drain_word(8'h96, 4, -1, 0, 1'b0);
      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h33;
      tick();
      rst        = 1'b0;
      load_valid = 1'b0;
      check_idle(8'h00);
      tick();
      check_idle(8'h00);
      accept(8'hA5);
      drain_word(8'hA5, 8, -1, 0, 1'b0);

      // Back-to-back offers: the second accept lands 9 edges after the first.
      load_valid = 1'b1;
      load_data  = 8'h01;
      ser_ready  = 1'b1;
      tick();
      check("b2b_first_word", mux_in_a, 8'h01);
      load_data = 8'h80;
      cycles = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cycles++;
         if (busy_a && mux_in_a == 8'h80) break;
      end
      load_valid = 1'b0;
      check("b2b_gap", 8'(cycles), 8'd9);
      if (cycles < 20) drain_word(8'h80, 8, -1, 0, 1'b0);

      // Random words with random stalls.
      for (int n = 0; n < 25; n++) begin
         w = 8'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         accept(w);
         drain_word(w, 8, -1, 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
